// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
// Holds the operand-select codes, the per-stage tracking record and a helper
// that decides whether a tracked stage produces a given source register.
package forward_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;

    // Operand-select codes seen by the EX-stage ALU input muxes.
    localparam logic [1:0] FWD_NONE  = 2'b00;   // value from the ID/EX register
    localparam logic [1:0] FWD_EXMEM = 2'b10;   // result held in EX/MEM
    localparam logic [1:0] FWD_MEMWB = 2'b01;   // result held in MEM/WB

    // What we need to remember about an instruction as it moves down the pipe.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_entry_t;

    // An empty slot: writes nothing, so it can never match a source.
    localparam stage_entry_t STAGE_BUBBLE = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};

    // A stage produces addr only if it really writes a register other than x0.
    function automatic logic produces_reg(
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] addr
    );
        return reg_write && (rd != '0) && (rd == addr);
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_match.sv
// Maps one source register address onto a forward code, given the instruction
// that will sit in EX/MEM and the one that will sit in MEM/WB next cycle.
// The EX/MEM candidate is younger, so it wins when both match.
module fwd_match
    import forward_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    output logic [1:0]            fwd_code
);

    // Older match first, then let the newer result overwrite it.
    always_comb begin
        fwd_code = FWD_NONE;
        if (produces_reg(memwb_reg_write, memwb_rd, src_addr)) begin
            fwd_code = FWD_MEMWB;
        end
        if (produces_reg(exmem_reg_write, exmem_rd, src_addr)) begin
            fwd_code = FWD_EXMEM;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a classic 5-stage pipeline.
// Tracks rd/RegWrite/MemRead for the EX, MEM and WB stages and, on the edge
// that moves an instruction from ID into EX, registers the operand-select codes
// it will need in EX. Stall_o flags a load-use hazard combinationally.
// Optional build macro: FWD_STALL_CNT_EN adds the saturating StallCnt_o counter.
module forward_ctrl
    import forward_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_ADDR_W-1:0]  ID_RS1addr_i,
    input  logic [REG_ADDR_W-1:0]  ID_RS2addr_i,
    input  logic [REG_ADDR_W-1:0]  ID_RDaddr_i,
    input  logic                   ID_RegWrite_i,
    input  logic                   ID_MemRead_i,
    input  logic                   Flush_i,
    output logic [1:0]             ForwardA_o,
    output logic [1:0]             ForwardB_o,
`ifdef FWD_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] StallCnt_o,
`endif
    output logic                   Stall_o
);

    localparam int NUM_SRC   = 2;   // operand A (rs1) and operand B (rs2)
    localparam int NUM_STAGE = 3;   // index 0 = EX, 1 = MEM, 2 = WB

    stage_entry_t          stage_reg [NUM_STAGE];
    stage_entry_t          ex_next;
    logic                  stall;
    logic                  kill_id;
    logic [REG_ADDR_W-1:0] src_addr  [NUM_SRC];
    logic [1:0]            code_next [NUM_SRC];
    logic [1:0]            fwd_reg   [NUM_SRC];

    assign src_addr[0] = ID_RS1addr_i;
    assign src_addr[1] = ID_RS2addr_i;

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    always_comb begin
        stall = stage_reg[0].mem_read && (stage_reg[0].rd != '0) &&
                ((stage_reg[0].rd == ID_RS1addr_i) || (stage_reg[0].rd == ID_RS2addr_i));
    end

    // Stall or flush both turn the ID instruction into a bubble on its way into EX.
    always_comb begin
        kill_id = stall || Flush_i;
        ex_next = '{rd: ID_RDaddr_i, reg_write: ID_RegWrite_i, mem_read: ID_MemRead_i};
        if (kill_id) begin
            ex_next = STAGE_BUBBLE;
        end
    end

    // Current EX becomes next EX/MEM, current MEM becomes next MEM/WB.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_match u_fwd_match (
                .src_addr        (src_addr[gi]),
                .exmem_rd        (stage_reg[0].rd),
                .exmem_reg_write (stage_reg[0].reg_write),
                .memwb_rd        (stage_reg[1].rd),
                .memwb_reg_write (stage_reg[1].reg_write),
                .fwd_code        (code_next[gi])
            );
        end
    endgenerate

    // Shift the stage trackers; EX takes the (possibly squashed) ID instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stage_reg[i] <= STAGE_BUBBLE;
            end
        end else begin
            stage_reg[0] <= ex_next;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    // Register the codes so they hold for the whole EX cycle of the instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fwd_reg[i] <= FWD_NONE;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fwd_reg[i] <= kill_id ? FWD_NONE : code_next[i];
            end
        end
    end

    assign ForwardA_o = fwd_reg[0];
    assign ForwardB_o = fwd_reg[1];
    assign Stall_o    = stall;

`ifdef FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    // Count load-use stall cycles, sticking at all-ones.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign StallCnt_o = stall_cnt_reg;
`endif

endmodule
